// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - write-back stage bus: ALU, long-latency, issue and register-file signals
interface writeback_unit_if #(
   parameter int DEPTH = 4
);
   logic                     alu_valid;
   logic [4:0]               alu_reg_w;
   logic [31:0]              alu_data;
   logic                     lsu_valid;
   logic                     lsu_ready;
   logic [4:0]               lsu_reg_w;
   logic [31:0]              lsu_data;
   logic                     issue_valid;
   logic [4:0]               issue_reg;
   logic                     issue_ready;
   logic [31:0]              busy;
   logic [4:0]               reg_w;
   logic                     reg_write_en;
   logic [31:0]              reg_write_data;
   logic [$clog2(DEPTH):0]   fifo_count;

   modport master (
      output alu_valid, alu_reg_w, alu_data,
      output lsu_valid, lsu_reg_w, lsu_data,
      output issue_valid, issue_reg,
      input  lsu_ready, issue_ready, busy,
      input  reg_w, reg_write_en, reg_write_data, fifo_count
   );

   modport slave (
      input  alu_valid, alu_reg_w, alu_data,
      input  lsu_valid, lsu_reg_w, lsu_data,
      input  issue_valid, issue_reg,
      output lsu_ready, issue_ready, busy,
      output reg_w, reg_write_en, reg_write_data, fifo_count
   );
endinterface

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - write-back merge of ALU and long-latency results with pending-destination scoreboard
module writeback_unit #(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   writeback_unit_if.slave  wb
);
   localparam int AW = $clog2(DEPTH);

   logic [4:0]  fifo_reg  [DEPTH];
   logic [31:0] fifo_data [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [31:0]   busy, busy_nxt;
   logic [4:0]    out_reg;
   logic          out_en;
   logic [31:0]   out_data;

   logic push, pop, issue_take;
   logic [4:0]  head_reg;
   logic [31:0] head_data;

   assign head_reg   = fifo_reg[rd_ptr];
   assign head_data  = fifo_data[rd_ptr];
   // Readiness uses the registered count only, so a full FIFO refuses even while popping.
   assign wb.lsu_ready   = (count < (AW+1)'(DEPTH));
   assign wb.issue_ready = ~busy[wb.issue_reg];
   assign push       = wb.lsu_valid && wb.lsu_ready;
   assign pop        = !wb.alu_valid && (count != '0);
   assign issue_take = wb.issue_valid && wb.issue_ready;

   // Set is applied after clear so a same-edge set of the popped register wins.
   always_comb begin
      busy_nxt = busy;
      if (pop)
         busy_nxt[head_reg] = 1'b0;
      if (issue_take && (wb.issue_reg != 5'd0))
         busy_nxt[wb.issue_reg] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_reg[wr_ptr]  <= wb.lsu_reg_w;
         fifo_data[wr_ptr] <= wb.lsu_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         busy   <= '0;
      end else begin
         busy <= busy_nxt;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Writes to $0 still load the address/data but never assert the enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_reg  <= '0;
         out_en   <= 1'b0;
         out_data <= '0;
      end else if (wb.alu_valid) begin
         out_reg  <= wb.alu_reg_w;
         out_en   <= (wb.alu_reg_w != 5'd0);
         out_data <= wb.alu_data;
      end else if (pop) begin
         out_reg  <= head_reg;
         out_en   <= (head_reg != 5'd0);
         out_data <= head_data;
      end else begin
         out_en   <= 1'b0;
      end
   end

   assign wb.busy           = busy;
   assign wb.reg_w          = out_reg;
   assign wb.reg_write_en   = out_en;
   assign wb.reg_write_data = out_data;
   assign wb.fifo_count     = count;
endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit
module tb_writeback_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   writeback_unit_if #(.DEPTH(4)) wb();

   writeback_unit #(.DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int idx;
   logic rdy;

   initial begin
      wb.alu_valid = 0; wb.alu_reg_w = 0; wb.alu_data = 0;
      wb.lsu_valid = 0; wb.lsu_reg_w = 0; wb.lsu_data = 0;
      wb.issue_valid = 0; wb.issue_reg = 0;

      // Reset / idle
      #2;
      check("rst_en",    32'(wb.reg_write_en), 32'd0);
      check("rst_w",     32'(wb.reg_w), 32'd0);
      check("rst_data",  wb.reg_write_data, 32'd0);
      check("rst_busy",  wb.busy, 32'd0);
      check("rst_cnt",   32'(wb.fifo_count), 32'd0);
      check("rst_lrdy",  32'(wb.lsu_ready), 32'd1);
      check("rst_irdy",  32'(wb.issue_ready), 32'd1);
      step(); step();
      rst = 1'b0;
      step();

      // ALU path
      wb.alu_valid = 1; wb.alu_reg_w = 5'd5; wb.alu_data = 32'hDEADBEEF;
      step();
      wb.alu_valid = 0;
      check("alu_en",   32'(wb.reg_write_en), 32'd1);
      check("alu_w",    32'(wb.reg_w), 32'd5);
      check("alu_data", wb.reg_write_data, 32'hDEADBEEF);
      step();
      check("alu_en_off", 32'(wb.reg_write_en), 32'd0);
      check("alu_hold_w", 32'(wb.reg_w), 32'd5);
      check("alu_hold_d", wb.reg_write_data, 32'hDEADBEEF);
      wb.alu_valid = 1; wb.alu_reg_w = 5'd0; wb.alu_data = 32'h11;
      step();
      wb.alu_valid = 0;
      check("alu_r0_en", 32'(wb.reg_write_en), 32'd0);

      // Scoreboard round trip
      wb.issue_reg = 5'd8; wb.issue_valid = 1;
      #1 check("sb_irdy_pre", 32'(wb.issue_ready), 32'd1);
      step();
      check("sb_busy_set", wb.busy, 32'h0000_0100);
      check("sb_irdy_low", 32'(wb.issue_ready), 32'd0);
      step();
      wb.issue_valid = 0;
      check("sb_reissue_ign", wb.busy, 32'h0000_0100);
      wb.lsu_valid = 1; wb.lsu_reg_w = 5'd8; wb.lsu_data = 32'h12345678;
      step();
      wb.lsu_valid = 0;
      check("sb_cnt1",  32'(wb.fifo_count), 32'd1);
      check("sb_en_wait", 32'(wb.reg_write_en), 32'd0);
      step();
      check("sb_pop_en", 32'(wb.reg_write_en), 32'd1);
      check("sb_pop_w",  32'(wb.reg_w), 32'd8);
      check("sb_pop_d",  wb.reg_write_data, 32'h12345678);
      check("sb_busy_clr", wb.busy, 32'd0);
      check("sb_irdy_back", 32'(wb.issue_ready), 32'd1);
      check("sb_cnt0",  32'(wb.fifo_count), 32'd0);
      step();

      // Priority and fill: ALU held 6 cycles while 5 LSU results are offered
      idx = 0;
      for (int c = 0; c < 6; c++) begin
         wb.alu_valid = 1; wb.alu_reg_w = 5'd1; wb.alu_data = 32'hA0 + 32'(c);
         wb.lsu_valid = (idx < 5);
         wb.lsu_reg_w = 5'(10 + idx); wb.lsu_data = 32'hC000_0000 + 32'(idx);
         #1 rdy = wb.lsu_ready;
         step();
         if (wb.lsu_valid && rdy) idx++;
         check("pri_alu_d", wb.reg_write_data, 32'hA0 + 32'(c));
      end
      check("fill_acc",  32'(idx), 32'd4);
      check("fill_cnt",  32'(wb.fifo_count), 32'd4);
      check("fill_lrdy", 32'(wb.lsu_ready), 32'd0);
      wb.alu_valid = 0;
      for (int k = 0; k < 5; k++) begin
         wb.lsu_valid = (idx < 5);
         wb.lsu_reg_w = 5'(10 + idx); wb.lsu_data = 32'hC000_0000 + 32'(idx);
         #1 rdy = wb.lsu_ready;
         if (k == 0) check("drain_full_rdy", 32'(rdy), 32'd0);
         if (k == 1) check("drain_rdy_back", 32'(rdy), 32'd1);
         step();
         if (wb.lsu_valid && rdy) idx++;
         if (k == 1) check("fifth_taken", 32'(idx), 32'd5);
         check("drain_en", 32'(wb.reg_write_en), 32'd1);
         check("drain_w",  32'(wb.reg_w), 32'(10 + k));
         check("drain_d",  wb.reg_write_data, 32'hC000_0000 + 32'(k));
      end
      wb.lsu_valid = 0;
      step();
      check("drain_idle_en", 32'(wb.reg_write_en), 32'd0);
      check("drain_idle_cnt", 32'(wb.fifo_count), 32'd0);

      // Wrap-around: 20 streamed results with ALU idle
      for (int i = 0; i <= 20; i++) begin
         wb.lsu_valid = (i < 20);
         wb.lsu_reg_w = 5'((i % 31) + 1);
         wb.lsu_data  = 32'h5000_0000 + 32'(i * 3);
         #1 if (i < 20) check("wrap_lrdy", 32'(wb.lsu_ready), 32'd1);
         step();
         check("wrap_cnt_le1", 32'(wb.fifo_count <= 1), 32'd1);
         if (i >= 1) begin
            check("wrap_en", 32'(wb.reg_write_en), 32'd1);
            check("wrap_w",  32'(wb.reg_w), 32'(((i - 1) % 31) + 1));
            check("wrap_d",  wb.reg_write_data, 32'h5000_0000 + 32'((i - 1) * 3));
         end
      end
      wb.lsu_valid = 0;
      step();

      // Async reset mid-operation
      wb.issue_valid = 1; wb.issue_reg = 5'd3;
      step();
      wb.issue_reg = 5'd9;
      step();
      wb.issue_valid = 0;
      for (int i = 0; i < 3; i++) begin
         wb.alu_valid = 1; wb.alu_reg_w = 5'd2; wb.alu_data = 32'h77;
         wb.lsu_valid = 1; wb.lsu_reg_w = (i == 0) ? 5'd3 : (i == 1) ? 5'd9 : 5'd20;
         wb.lsu_data = 32'hEE00 + 32'(i);
         step();
      end
      wb.alu_valid = 0; wb.lsu_valid = 0;
      check("ar_pre_cnt",  32'(wb.fifo_count), 32'd3);
      check("ar_pre_busy", wb.busy, 32'h0000_0208);
      check("ar_pre_en",   32'(wb.reg_write_en), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("ar_en",   32'(wb.reg_write_en), 32'd0);
      check("ar_w",    32'(wb.reg_w), 32'd0);
      check("ar_data", wb.reg_write_data, 32'd0);
      check("ar_busy", wb.busy, 32'd0);
      check("ar_cnt",  32'(wb.fifo_count), 32'd0);
      check("ar_lrdy", 32'(wb.lsu_ready), 32'd1);
      #2 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("ar_post_en",  32'(wb.reg_write_en), 32'd0);
         check("ar_post_cnt", 32'(wb.fifo_count), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
